main_memory_responder: RTL and testbench
========================================

// Module: main_memory_responder
// PURPOSE
// Memory-side responder for the cache's miss/refill interface. On a cache miss the
// cache controller issues a read request; this block waits a fixed access latency,
// then streams one aligned block of BLOCK_WORDS words back. Write-through stores are
// accepted as single-word writes and acknowledged after the same latency.
// Sits under Top, between the cache controller and the memory array; memOutData
// observation in system benches is driven from rsp_data.
// PARAMETERS
// ADDR_W       8   byte-address width; array depth = 2**ADDR_W words
// DATA_W       8   word width
// BLOCK_WORDS  4   words per cache block (power of 2, >=1)
// LATENCY      3   wait cycles between request accept and first response beat (>=0)
// PORTS
// clk        in   1                   rising-edge clock
// Reset      in   1                   synchronous, active-high reset
// req_valid  in   1                   request present
// req_ready  out  1                   1 only in IDLE; accept = req_valid & req_ready
// req_write  in   1                   1 = single-word write, 0 = block read
// req_addr   in   ADDR_W              request address
// req_wdata  in   DATA_W              write data (ignored for reads)
// rsp_valid  out  1                   response beat valid (no backpressure)
// rsp_data   out  DATA_W              read word / echoed write data
// rsp_index  out  clog2(BLOCK_WORDS)  beat index within block (0 when BLOCK_WORDS=1)
// rsp_last   out  1                   final beat of response
// busy       out  1                   ~IDLE
// BEHAVIOUR
// - One clock (clk); Reset is synchronous and active-high; it dominates every other input.
// - Reset: state=IDLE; req_ready=1 on the cycle after Reset deasserts; rsp_valid=0,
//   rsp_data=0, rsp_index=0, rsp_last=0, busy=0; array re-initialised mem[a]=a[DATA_W-1:0].
// - FSM states: IDLE, WAIT, BURST, WACK.
//   - IDLE: on accept, latch write flag and base address.
//     - Read: base = req_addr with the low clog2(BLOCK_WORDS) bits cleared.
//     - Write: mem[req_addr] <= req_wdata at the accept edge.
//     - Next state: WAIT if LATENCY>0; otherwise BURST (read) or WACK (write).
//   - WAIT: counter runs 1..LATENCY. On count==LATENCY go to BURST (read) or WACK (write).
//   - BURST: each cycle rsp_valid=1, rsp_data=mem[base+k], rsp_index=k, k=0..BLOCK_WORDS-1;
//     rsp_last=1 at k=BLOCK_WORDS-1, then go to IDLE.
//   - WACK: single beat with rsp_valid=1, rsp_last=1, rsp_index=0, rsp_data=written word;
//     then go to IDLE.
// - Timing: accept at edge N -> first beat registered, visible N+1+LATENCY to N+2+LATENCY;
//   read beats contiguous; next accept possible on the cycle after the last beat.
// - Outputs are registered; rsp_* hold 0 whenever rsp_valid=0.
// - Base is aligned, so a block never crosses 2**ADDR_W. The top block (0xFC..0xFF for
//   defaults) is legal; offset arithmetic is ADDR_W bits wide.
// - A write followed by a read of the same block returns the new data (write commits at accept).
// - req_valid while busy: ignored, not queued; the requester must hold it until accepted.
// - Reset mid-WAIT/BURST: the transaction is dropped, no further beats, outputs cleared next
//   edge; earlier writes are lost (array re-initialised).
// - BLOCK_WORDS=1: BURST is a single beat with rsp_last=1.
// TESTING
// 1 Reset, then read addr 0x13 -> req_ready low; 3 idle cycles; beats 0x10,0x11,0x12,0x13 with
//   index 0..3, rsp_last only on 0x13; req_ready high on the following cycle.
// 2 Write 0x42 to addr 0x21 -> single ack beat 4 cycles after accept, rsp_data=0x42,
//   rsp_last=1; then read 0x20 -> 0x20,0x42,0x22,0x23.
// 3 Read 0xFE (top block) -> 0xFC,0xFD,0xFE,0xFF; no wrap to 0x00.
// 4 Hold req_valid through an active burst with a different addr -> ignored until IDLE,
//   then accepted; exactly one response per accept.
// 5 Assert Reset on the 2nd burst beat -> rsp_valid=0 next cycle and no more beats; prior
//   write to 0x21 reads back 0x21.
// 6 LATENCY=0, BLOCK_WORDS=1 build: read 0x05 -> beat 0x05 on the cycle right after accept,
//   rsp_last=1.

Source files
------------

// File: rtl/main_memory_responder.sv
// Memory-side responder for cache miss/refill: a block read streams BLOCK_WORDS aligned words;
// a single-word write is acknowledged with one beat that echoes the written word.
// Latency: the first response beat is registered LATENCY+1 edges after the accept edge.
//   Read beats follow back to back, and the next accept can happen on the cycle after the last beat.
// Backpressure: req_ready is high only in IDLE, and a request seen while busy is not queued.
//   Responses cannot be stalled.
// Ports:
//   clk, Reset (synchronous, active-high)
//   req_valid/req_ready/req_write/req_addr/req_wdata: request handshake and payload
//   rsp_valid/rsp_data/rsp_index/rsp_last: response beats; all fields are 0 when rsp_valid=0
//   busy: the block is not idle
module main_memory_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 3,
  localparam int IDX_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [IDX_W-1:0]  rsp_index,
  output logic              rsp_last,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(LATENCY + 1) + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    beat_q;
  logic                accept;

  // Next values of the registered response outputs.
  logic [IDX_W-1:0]    beat_d;
  logic                valid_d;
  logic [DATA_W-1:0]   data_d;
  logic [IDX_W-1:0]    index_d;
  logic                last_d;

  assign accept = req_valid & req_ready;

  // Array: reset reloads the identity pattern. Writes commit at the accept edge,
  // so a read that follows already sees the new data.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (accept && req_write) begin
      mem[req_addr] <= req_wdata;
    end
  end

  // State register, request latches, and registered outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_index <= '0;
      rsp_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      beat_q    <= beat_d;
      rsp_valid <= valid_d;
      rsp_data  <= data_d;
      rsp_index <= index_d;
      rsp_last  <= last_d;
      cnt_q     <= (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
      if (accept) begin
        wr_q    <= req_write;
        base_q  <= req_write ? req_addr : (req_addr & ~OFF_MASK);
        wdata_q <= req_wdata;
      end
    end
  end

  // WAIT counts 0..LATENCY (LATENCY+1 cycles). Because the outputs are registered
  // from the next state, the first beat becomes visible LATENCY+1 edges after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == LAT_CNT) state_d = wr_q ? WACK : BURST;
      BURST:   if (beat_q == LAST_IDX) state_d = IDLE;
      WACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // beat_q holds the index of the beat currently on the outputs.
  always_comb begin
    beat_d  = (state_q == BURST) ? beat_q + IDX_W'(1) : '0;
    valid_d = 1'b0;
    data_d  = '0;
    index_d = '0;
    last_d  = 1'b0;
    case (state_d)
      BURST: begin
        valid_d = 1'b1;
        // The base is aligned, so the sum never crosses the top of the array.
        data_d  = mem[base_q + ADDR_W'(beat_d)];
        index_d = beat_d;
        last_d  = (beat_d == LAST_IDX);
      end
      WACK: begin
        valid_d = 1'b1;
        data_d  = wdata_q;
        last_d  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;
  localparam int L  = 3;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset, req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata, rsp_data;
  logic       rsp_valid, rsp_last, busy;
  logic [1:0] rsp_index;

  // Second build: LATENCY=0, BLOCK_WORDS=1
  logic       s_valid, s_ready, s_write, s_rsp_valid, s_rsp_last, s_busy;
  logic [7:0] s_addr, s_wdata, s_rsp_data;
  logic [0:0] s_rsp_index;

  main_memory_responder #(.ADDR_W(8), .DATA_W(8), .BLOCK_WORDS(BW), .LATENCY(L)) u_dut (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_index(rsp_index),
    .rsp_last(rsp_last), .busy(busy));

  main_memory_responder #(.ADDR_W(8), .DATA_W(8), .BLOCK_WORDS(1), .LATENCY(0)) u_dut1 (
    .clk(clk), .Reset(Reset), .req_valid(s_valid), .req_ready(s_ready),
    .req_write(s_write), .req_addr(s_addr), .req_wdata(s_wdata),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_index(s_rsp_index),
    .rsp_last(s_rsp_last), .busy(s_busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: array contents plus a schedule of expected beats,
  // each tagged with the absolute clock edge after which it must be visible.
  typedef struct {int e; logic [7:0] d; logic [1:0] i; logic l;} beat_t;
  beat_t      q[$];
  beat_t      seen[$];
  beat_t      b;
  logic [7:0] mmem [256];
  int         edge_no = 0;
  int         free_edge = 0;
  logic       m_ready = 1'b0, armed = 1'b0, rst_edge = 1'b0;
  logic       c_rst, c_v, c_w;
  logic [7:0] c_a, c_d, base, ad;
  logic       exp_v, exp_l;
  logic [7:0] exp_d;
  logic [1:0] exp_i;

  always begin
    @(posedge clk);
    c_rst = Reset; c_v = req_valid; c_w = req_write; c_a = req_addr; c_d = req_wdata;
    edge_no++;
    if (c_rst) begin
      for (int i = 0; i < 256; i++) mmem[i] = 8'(i);
      q.delete();
      free_edge = edge_no + 1;
      rst_edge  = 1'b1;
      armed     = 1'b1;
    end else begin
      rst_edge = 1'b0;
      if (armed && c_v && m_ready) begin
        if (c_w) begin
          mmem[c_a] = c_d;
          b.e = edge_no + 1 + L; b.d = c_d; b.i = 2'd0; b.l = 1'b1;
          q.push_back(b);
          free_edge = edge_no + 2 + L;
        end else begin
          base = c_a & ~8'(BW - 1);
          for (int k = 0; k < BW; k++) begin
            ad = base + 8'(k);
            b.e = edge_no + 1 + L + k; b.d = mmem[ad]; b.i = 2'(k); b.l = (k == BW - 1);
            q.push_back(b);
          end
          free_edge = edge_no + 1 + L + BW;
        end
      end
    end
    m_ready = armed && !rst_edge && (edge_no >= free_edge);
    #1;
    if (armed) begin
      exp_v = 1'b0; exp_d = 8'h00; exp_i = 2'd0; exp_l = 1'b0;
      if (q.size() > 0 && q[0].e == edge_no) begin
        b = q.pop_front();
        exp_v = 1'b1; exp_d = b.d; exp_i = b.i; exp_l = b.l;
      end
      chk("rsp_valid", rsp_valid, exp_v);
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_index", rsp_index, exp_i);
      chk("rsp_last", rsp_last, exp_l);
      chk("req_ready", req_ready, m_ready);
      chk("busy", busy, armed && !rst_edge && (edge_no < free_edge));
    end
    if (rsp_valid === 1'b1) begin
      b.e = edge_no; b.d = rsp_data; b.i = rsp_index; b.l = rsp_last;
      seen.push_back(b);
    end
  end

  int acc_edge;

  // Called at a negedge: hold the request until the DUT is ready, then release it
  // one cycle after the accepting edge.
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("send_timeout", req_ready, 1);
    acc_edge = edge_no + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_block(input string nm, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    chk({nm, "_count"}, seen.size(), 4);
    if (seen.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk({nm, "_data"}, seen[k].d, w[k]);
        chk({nm, "_idx"}, seen[k].i, k);
        chk({nm, "_last"}, seen[k].l, k == 3);
      end
      chk({nm, "_contig"}, seen[3].e - seen[0].e, 3);
    end
  endtask

  initial begin
    int n;
    Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    s_valid = 1'b0; s_write = 1'b0; s_addr = 8'h00; s_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    Reset = 1'b0;

    // Aligned read of the block holding 0x13
    seen.delete();
    send(1'b0, 8'h13, 8'h00);
    idle(8);
    chk_block("t1", 8'h10, 8'h11, 8'h12, 8'h13);
    if (seen.size() > 0) chk("t1_latency", seen[0].e - acc_edge, 4);

    // Write, acknowledged with the written word
    seen.delete();
    send(1'b1, 8'h21, 8'h42);
    idle(6);
    chk("t2_count", seen.size(), 1);
    if (seen.size() == 1) begin
      chk("t2_data", seen[0].d, 8'h42);
      chk("t2_last", seen[0].l, 1);
      chk("t2_latency", seen[0].e - acc_edge, 4);
    end
    seen.delete();
    send(1'b0, 8'h20, 8'h00);
    idle(8);
    chk_block("t2r", 8'h20, 8'h42, 8'h22, 8'h23);

    // Top block, no wrap
    seen.delete();
    send(1'b0, 8'hFE, 8'h00);
    idle(8);
    chk_block("t3", 8'hFC, 8'hFD, 8'hFE, 8'hFF);

    // Second request held through the first burst
    seen.delete();
    send(1'b0, 8'h40, 8'h00);
    send(1'b0, 8'h81, 8'h00);
    idle(8);
    chk("t4_count", seen.size(), 8);
    if (seen.size() == 8) begin
      chk("t4_first", seen[0].d, 8'h40);
      chk("t4_second", seen[4].d, 8'h80);
      chk("t4_last_a", seen[3].l, 1);
      chk("t4_last_b", seen[7].l, 1);
    end

    // Reset on the second beat of a burst
    seen.delete();
    send(1'b0, 8'h30, 8'h00);
    n = 0;
    while (!(rsp_valid === 1'b1 && rsp_index == 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_beat1", rsp_index, 1);
    Reset = 1'b1;
    @(negedge clk);
    chk("t5_valid_after_reset", rsp_valid, 0);
    Reset = 1'b0;
    idle(6);
    chk("t5_beats", seen.size(), 2);
    seen.delete();
    send(1'b0, 8'h21, 8'h00);
    idle(8);
    chk_block("t5r", 8'h20, 8'h21, 8'h22, 8'h23);

    // LATENCY=0, BLOCK_WORDS=1 build
    chk("t6_ready", s_ready, 1);
    s_valid = 1'b1; s_addr = 8'h05;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid", s_rsp_valid, 1);
    chk("t6_data", s_rsp_data, 8'h05);
    chk("t6_last", s_rsp_last, 1);
    chk("t6_index", s_rsp_index, 0);
    chk("t6_busy", s_busy, 1);
    @(negedge clk);
    chk("t6_valid_after", s_rsp_valid, 0);
    chk("t6_ready_after", s_ready, 1);

    // Randomized traffic, including requests while busy and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      Reset     = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = ($urandom_range(0, 2) == 0);
      req_addr  = 8'($urandom_range(0, 255));
      req_wdata = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    Reset = 1'b0; req_valid = 1'b0;
    idle(12);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
